// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
//   wb_req_t   : one lane write request {en, addr, data}
//   lq_entry_t : one long-latency queue slot {valid, addr, data}
//   REG_ZERO   : architectural zero register; writes to it are dropped
//   addr_hit() : true when an enabled writer targets the given address
// The struct field widths are XLEN_W / AW_W; the modules default their
// XLEN / AW parameters to these so the types and ports line up.
package wb_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned AW_W   = 5;

  localparam logic [AW_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              en;
    logic [AW_W-1:0]   addr;
    logic [XLEN_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic              valid;
    logic [AW_W-1:0]   addr;
    logic [XLEN_W-1:0] data;
  } lq_entry_t;

  function automatic logic addr_hit(input logic            en,
                                    input logic [AW_W-1:0] kill_addr,
                                    input logic [AW_W-1:0] addr);
    return en && (kill_addr == addr);
  endfunction

endpackage

// File: rtl/wb_arbiter_lq_fifo.sv
// Long-latency result queue for the writeback arbiter.
// FIFO of lq_entry_t with per-entry kill-by-address, up to two pops per
// cycle and an occupancy count.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, push_entry_i   enqueue strobe and entry (valid=0 for x0 targets)
//   kill{0,1}_en_i/addr_i  lane writes this cycle; matching entries are
//                          invalidated, including the one being pushed
//   pop_cnt_i              number of entries retired this cycle (0..2)
//   head0_o, head1_o       head and head+1, valid already masked by
//                          occupancy and by this cycle's kills
//   count_o                occupied slots
//   ready_o                space available (state only)
module lq_fifo
  import wb_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  lq_entry_t        push_entry_i,
  input  logic             kill0_en_i,
  input  logic [AW_W-1:0]  kill0_addr_i,
  input  logic             kill1_en_i,
  input  logic [AW_W-1:0]  kill1_addr_i,
  input  logic [1:0]       pop_cnt_i,
  output lq_entry_t        head0_o,
  output lq_entry_t        head1_o,
  output logic [CW-1:0]    count_o,
  output logic             ready_o
);

  lq_entry_t       mem_q [QDEPTH];
  lq_entry_t       mem_d [QDEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nx;
  logic [CW-1:0]   count_q, count_d;

  // Head views: a lane writing the same register this cycle is younger, so
  // the queued value is stale and must not reach a port.
  always_comb begin
    rd_ptr_nx     = rd_ptr_q + PW'(1);
    head0_o       = mem_q[rd_ptr_q];
    head0_o.valid = mem_q[rd_ptr_q].valid && (count_q >= CW'(1))
                    && !addr_hit(kill0_en_i, kill0_addr_i, mem_q[rd_ptr_q].addr)
                    && !addr_hit(kill1_en_i, kill1_addr_i, mem_q[rd_ptr_q].addr);
    head1_o       = mem_q[rd_ptr_nx];
    head1_o.valid = mem_q[rd_ptr_nx].valid && (count_q >= CW'(2))
                    && !addr_hit(kill0_en_i, kill0_addr_i, mem_q[rd_ptr_nx].addr)
                    && !addr_hit(kill1_en_i, kill1_addr_i, mem_q[rd_ptr_nx].addr);
  end

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push_i && (wr_ptr_q == PW'(i))) begin
        mem_d[i] = push_entry_i;
      end
      mem_d[i].valid = mem_d[i].valid
                       && !addr_hit(kill0_en_i, kill0_addr_i, mem_d[i].addr)
                       && !addr_hit(kill1_en_i, kill1_addr_i, mem_d[i].addr);
    end
  end

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_cnt_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_cnt_i);
  end

  // Storage is not reset: count and pointers alone decide what is live.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign ready_o = (count_q < CW'(QDEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of a dual-write-port register file.
// Merges two in-order lanes and one long-latency unit into at most two
// register writes per cycle, buffering long-latency results until a port
// is free and never issuing two writes to one address in a cycle.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   wb0_en/addr/data              lane 0 (older) write request
//   wb1_en/addr/data              lane 1 (younger) write request
//   lu_valid/lu_addr/lu_data      long-latency result, lu_ready accepts
//   we3/wa3/wd3, we4/wa4/wd4      registered register file write ports
//   q_count                       occupied long-latency queue slots
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN   = XLEN_W,
  parameter int AW     = AW_W,
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wb0_en,
  input  logic [AW-1:0]            wb0_addr,
  input  logic [XLEN-1:0]          wb0_data,
  input  logic                     wb1_en,
  input  logic [AW-1:0]            wb1_addr,
  input  logic [XLEN-1:0]          wb1_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [AW-1:0]            lu_addr,
  input  logic [XLEN-1:0]          lu_data,
  output logic                     we3,
  output logic                     we4,
  output logic [AW-1:0]            wa3,
  output logic [AW-1:0]            wa4,
  output logic [XLEN-1:0]          wd3,
  output logic [XLEN-1:0]          wd4,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int CW = $clog2(QDEPTH) + 1;

  wb_req_t          lane0, lane1;
  logic             sup0, use3, use4;
  logic             free3, free4, placed0;
  lq_entry_t        push_entry, head0, head1;
  logic             push;
  logic [1:0]       pop_cnt;
  logic [CW-1:0]    count;

  logic             we3_d, we4_d, we3_q, we4_q;
  logic [AW-1:0]    wa3_d, wa4_d, wa3_q, wa4_q;
  logic [XLEN-1:0]  wd3_d, wd4_d, wd3_q, wd4_q;

  // Lane qualification: x0 targets are not effective; on a same-address
  // pair the younger lane 1 wins.
  always_comb begin
    lane0.en   = wb0_en && (wb0_addr != REG_ZERO);
    lane0.addr = wb0_addr;
    lane0.data = wb0_data;
    lane1.en   = wb1_en && (wb1_addr != REG_ZERO);
    lane1.addr = wb1_addr;
    lane1.data = wb1_data;
    sup0       = lane0.en && lane1.en && (lane0.addr == lane1.addr);
    use3       = lane0.en && !sup0;
    use4       = lane1.en;
  end

  always_comb begin
    push_entry.valid = (lu_addr != REG_ZERO);
    push_entry.addr  = lu_addr;
    push_entry.data  = lu_data;
    push             = lu_valid && lu_ready;
  end

  lq_fifo #(
    .QDEPTH(QDEPTH)
  ) u_lq_fifo (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .kill0_en_i   (lane0.en),
    .kill0_addr_i (lane0.addr),
    .kill1_en_i   (lane1.en),
    .kill1_addr_i (lane1.addr),
    .pop_cnt_i    (pop_cnt),
    .head0_o      (head0),
    .head1_o      (head1),
    .count_o      (count),
    .ready_o      (lu_ready)
  );

  // Port selection: lanes first, then queue entries in order into the
  // remaining ports (3 before 4). Killed entries retire without a port.
  always_comb begin
    we3_d   = use3;
    wa3_d   = use3 ? lane0.addr : '0;
    wd3_d   = use3 ? lane0.data : '0;
    we4_d   = use4;
    wa4_d   = use4 ? lane1.addr : '0;
    wd4_d   = use4 ? lane1.data : '0;
    free3   = !use3;
    free4   = !use4;
    placed0 = 1'b0;
    pop_cnt = 2'd0;

    if (count >= CW'(1)) begin
      if (!head0.valid) begin
        pop_cnt = 2'd1;
      end else if (free3) begin
        we3_d = 1'b1; wa3_d = head0.addr; wd3_d = head0.data;
        free3 = 1'b0; placed0 = 1'b1; pop_cnt = 2'd1;
      end else if (free4) begin
        we4_d = 1'b1; wa4_d = head0.addr; wd4_d = head0.data;
        free4 = 1'b0; placed0 = 1'b1; pop_cnt = 2'd1;
      end
    end

    // The second entry may share the head's address; holding it back one
    // cycle keeps the two ports on distinct registers and preserves order.
    if ((pop_cnt == 2'd1) && (count >= CW'(2))) begin
      if (!head1.valid) begin
        pop_cnt = 2'd2;
      end else if (!(placed0 && (head0.addr == head1.addr))) begin
        if (free3) begin
          we3_d = 1'b1; wa3_d = head1.addr; wd3_d = head1.data;
          pop_cnt = 2'd2;
        end else if (free4) begin
          we4_d = 1'b1; wa4_d = head1.addr; wd4_d = head1.data;
          pop_cnt = 2'd2;
        end
      end
    end
  end

  // Output register stage: one-cycle latency to the register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
      we4_q <= 1'b0;
      wa4_q <= '0;
      wd4_q <= '0;
    end else begin
      we3_q <= we3_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
      we4_q <= we4_d;
      wa4_q <= wa4_d;
      wd4_q <= wd4_d;
    end
  end

  assign we3     = we3_q;
  assign wa3     = wa3_q;
  assign wd3     = wd3_q;
  assign we4     = we4_q;
  assign wa4     = wa4_q;
  assign wd4     = wd4_q;
  assign q_count = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: scenario tasks drive per-cycle stimulus, push the
// expected port outputs and queue count to a scoreboard, and pop/compare
// them one edge later.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb0_en, wb1_en, lu_valid, lu_ready;
  logic [4:0]  wb0_addr, wb1_addr, lu_addr;
  logic [31:0] wb0_data, wb1_data, lu_data;
  logic        we3, we4;
  logic [4:0]  wa3, wa4;
  logic [31:0] wd3, wd4;
  logic [1:0]  q_count;
  logic [75:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        e0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        e1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        rdy;
    logic [75:0] ports;
    logic [1:0]  qc;
  } step_t;

  step_t sb[$];

  wb_arbiter #(.XLEN(32), .AW(5), .QDEPTH(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wb0_en   (wb0_en),
    .wb0_addr (wb0_addr),
    .wb0_data (wb0_data),
    .wb1_en   (wb1_en),
    .wb1_addr (wb1_addr),
    .wb1_data (wb1_data),
    .lu_valid (lu_valid),
    .lu_ready (lu_ready),
    .lu_addr  (lu_addr),
    .lu_data  (lu_data),
    .we3      (we3),
    .we4      (we4),
    .wa3      (wa3),
    .wa4      (wa4),
    .wd3      (wd3),
    .wd4      (wd4),
    .q_count  (q_count)
  );

  always #5 clk = ~clk;

  assign obs = {we3, wa3, wd3, we4, wa4, wd4};

  function automatic logic [75:0] pk(input logic w3, input logic [4:0] a3, input logic [31:0] d3,
                                     input logic w4, input logic [4:0] a4, input logic [31:0] d4);
    return {w3, a3, d3, w4, a4, d4};
  endfunction

  function automatic step_t mk(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic lv, input logic [4:0] la, input logic [31:0] ld,
                               input logic rdy, input logic [75:0] ports, input logic [1:0] qc);
    step_t s;
    s.e0 = e0; s.a0 = a0; s.d0 = d0;
    s.e1 = e1; s.a1 = a1; s.d1 = d1;
    s.lv = lv; s.la = la; s.ld = ld;
    s.rdy = rdy; s.ports = ports; s.qc = qc;
    return s;
  endfunction

  task automatic drive(input step_t s);
    wb0_en = s.e0; wb0_addr = s.a0; wb0_data = s.d0;
    wb1_en = s.e1; wb1_addr = s.a1; wb1_data = s.d1;
    lu_valid = s.lv; lu_addr = s.la; lu_data = s.ld;
  endtask

  localparam logic [75:0] NONE = 76'd0;

  task automatic test_reset();
    reset_n = 1'b0;
    drive(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, NONE, 2'd0));
    #3;
    checks++;
    if (obs !== NONE) begin errors++; $display("FAIL reset_ports got=%h want=%h", obs, NONE); end
    checks++;
    if (q_count !== 2'd0) begin errors++; $display("FAIL reset_qcount got=%0d want=0", q_count); end
    checks++;
    if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", lu_ready); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_lanes();
    step_t st[$];
    step_t e;
    st.push_back(mk(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 5'd0, 32'h0, 1'b1,
                    pk(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22), 2'd0));
    st.push_back(mk(1'b1, 5'd8, 32'h80, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                    pk(1'b1, 5'd8, 32'h80, 1'b0, 5'd0, 32'h0), 2'd0));
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 32'h0, 1'b1,
                    pk(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h90), 2'd0));
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, NONE, 2'd0));
    foreach (st[i]) begin
      drive(st[i]);
      #1;
      checks++;
      if (lu_ready !== st[i].rdy) begin errors++; $display("FAIL lanes_ready[%0d] got=%b want=%b", i, lu_ready, st[i].rdy); end
      sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ports) begin errors++; $display("FAIL lanes_ports[%0d] got=%h want=%h", i, obs, e.ports); end
      checks++;
      if (q_count !== e.qc) begin errors++; $display("FAIL lanes_qcount[%0d] got=%0d want=%0d", i, q_count, e.qc); end
    end
  endtask

  task automatic test_same_addr();
    step_t st[$];
    step_t e;
    st.push_back(mk(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'h0, 1'b1,
                    pk(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hBB), 2'd0));
    // lane 1 disabled on the same address must not suppress lane 0
    st.push_back(mk(1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1,
                    pk(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0), 2'd0));
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, NONE, 2'd0));
    foreach (st[i]) begin
      drive(st[i]);
      #1;
      checks++;
      if (lu_ready !== st[i].rdy) begin errors++; $display("FAIL waw_ready[%0d] got=%b want=%b", i, lu_ready, st[i].rdy); end
      sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ports) begin errors++; $display("FAIL waw_ports[%0d] got=%h want=%h", i, obs, e.ports); end
      checks++;
      if (q_count !== e.qc) begin errors++; $display("FAIL waw_qcount[%0d] got=%0d want=%0d", i, q_count, e.qc); end
    end
  endtask

  task automatic test_lu_single();
    step_t st[$];
    step_t e;
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, NONE, 2'd1));
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                    pk(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0), 2'd0));
    foreach (st[i]) begin
      drive(st[i]);
      #1;
      checks++;
      if (lu_ready !== st[i].rdy) begin errors++; $display("FAIL lu_ready[%0d] got=%b want=%b", i, lu_ready, st[i].rdy); end
      sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ports) begin errors++; $display("FAIL lu_ports[%0d] got=%h want=%h", i, obs, e.ports); end
      checks++;
      if (q_count !== e.qc) begin errors++; $display("FAIL lu_qcount[%0d] got=%0d want=%0d", i, q_count, e.qc); end
    end
  endtask

  task automatic test_fill_drain();
    step_t st[$];
    step_t e;
    st.push_back(mk(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd10, 32'h100, 1'b1,
                    pk(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2), 2'd1));
    st.push_back(mk(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 1'b1, 5'd11, 32'h111, 1'b1,
                    pk(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4), 2'd2));
    st.push_back(mk(1'b1, 5'd1, 32'hB1, 1'b1, 5'd2, 32'hB2, 1'b1, 5'd13, 32'h13, 1'b0,
                    pk(1'b1, 5'd1, 32'hB1, 1'b1, 5'd2, 32'hB2), 2'd2));
    // full queue drains both entries but still refuses x13 this cycle
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h13, 1'b0,
                    pk(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h111), 2'd0));
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h13, 1'b1, NONE, 2'd1));
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                    pk(1'b1, 5'd13, 32'h13, 1'b0, 5'd0, 32'h0), 2'd0));
    foreach (st[i]) begin
      drive(st[i]);
      #1;
      checks++;
      if (lu_ready !== st[i].rdy) begin errors++; $display("FAIL fill_ready[%0d] got=%b want=%b", i, lu_ready, st[i].rdy); end
      sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ports) begin errors++; $display("FAIL fill_ports[%0d] got=%h want=%h", i, obs, e.ports); end
      checks++;
      if (q_count !== e.qc) begin errors++; $display("FAIL fill_qcount[%0d] got=%0d want=%0d", i, q_count, e.qc); end
    end
  endtask

  task automatic test_kill();
    step_t st[$];
    step_t e;
    st.push_back(mk(1'b1, 5'd1, 32'hC1, 1'b1, 5'd2, 32'hC2, 1'b1, 5'd12, 32'h1, 1'b1,
                    pk(1'b1, 5'd1, 32'hC1, 1'b1, 5'd2, 32'hC2), 2'd1));
    st.push_back(mk(1'b1, 5'd12, 32'h2, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1,
                    pk(1'b1, 5'd12, 32'h2, 1'b1, 5'd3, 32'h33), 2'd0));
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, NONE, 2'd0));
    // result enqueued while lane 1 writes the same register is killed on entry
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h44, 1'b1, 5'd14, 32'h4, 1'b1,
                    pk(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h44), 2'd1));
    st.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, NONE, 2'd0));
    // queued entry fills port 4 when only lane 0 is active
    st.push_back(mk(1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 32'h0, 1'b1, 5'd21, 32'h21, 1'b1,
                    pk(1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 32'h0), 2'd1));
    st.push_back(mk(1'b1, 5'd22, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                    pk(1'b1, 5'd22, 32'h22, 1'b1, 5'd21, 32'h21), 2'd0));
    foreach (st[i]) begin
      drive(st[i]);
      #1;
      checks++;
      if (lu_ready !== st[i].rdy) begin errors++; $display("FAIL kill_ready[%0d] got=%b want=%b", i, lu_ready, st[i].rdy); end
      sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ports) begin errors++; $display("FAIL kill_ports[%0d] got=%h want=%h", i, obs, e.ports); end
      checks++;
      if (q_count !== e.qc) begin errors++; $display("FAIL kill_qcount[%0d] got=%0d want=%0d", i, q_count, e.qc); end
    end
  endtask

  task automatic test_x0_and_reset();
    step_t st[$];
    step_t post[$];
    step_t e;
    st.push_back(mk(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE, 1'b1, 5'd0, 32'hDD, 1'b1, NONE, 2'd1));
    st.push_back(mk(1'b1, 5'd1, 32'hD1, 1'b1, 5'd2, 32'hD2, 1'b1, 5'd15, 32'h15, 1'b1,
                    pk(1'b1, 5'd1, 32'hD1, 1'b1, 5'd2, 32'hD2), 2'd1));
    st.push_back(mk(1'b1, 5'd3, 32'hD3, 1'b1, 5'd4, 32'hD4, 1'b1, 5'd16, 32'h16, 1'b1,
                    pk(1'b1, 5'd3, 32'hD3, 1'b1, 5'd4, 32'hD4), 2'd2));
    foreach (st[i]) begin
      drive(st[i]);
      #1;
      checks++;
      if (lu_ready !== st[i].rdy) begin errors++; $display("FAIL x0_ready[%0d] got=%b want=%b", i, lu_ready, st[i].rdy); end
      sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ports) begin errors++; $display("FAIL x0_ports[%0d] got=%h want=%h", i, obs, e.ports); end
      checks++;
      if (q_count !== e.qc) begin errors++; $display("FAIL x0_qcount[%0d] got=%0d want=%0d", i, q_count, e.qc); end
    end

    // asynchronous reset with two entries queued
    drive(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, NONE, 2'd0));
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== NONE) begin errors++; $display("FAIL midreset_ports got=%h want=%h", obs, NONE); end
    checks++;
    if (q_count !== 2'd0) begin errors++; $display("FAIL midreset_qcount got=%0d want=0", q_count); end
    @(posedge clk); #1;
    reset_n = 1'b1;

    post.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, NONE, 2'd0));
    post.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, NONE, 2'd0));
    post.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, NONE, 2'd0));
    foreach (post[i]) begin
      drive(post[i]);
      #1;
      checks++;
      if (lu_ready !== post[i].rdy) begin errors++; $display("FAIL postreset_ready[%0d] got=%b want=%b", i, lu_ready, post[i].rdy); end
      sb.push_back(post[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ports) begin errors++; $display("FAIL postreset_ports[%0d] got=%h want=%h", i, obs, e.ports); end
      checks++;
      if (q_count !== e.qc) begin errors++; $display("FAIL postreset_qcount[%0d] got=%0d want=%0d", i, q_count, e.qc); end
    end
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_same_addr();
    test_lu_single();
    test_fill_drain();
    test_kill();
    test_x0_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
